// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory ready handshake with a bounded wait, and a sticky trap on illegal ops or timeouts.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        sext,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } state_t;

    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

    state_t        cur;
    logic [CW-1:0] waitCnt;

    logic [5:0] op;
    logic [5:0] funct;
    logic       isR, rOk, isLw, isSw, isBeq, isBne, isAddi, isAddiu;
    logic       isAndi, isOri, isLui, isJ, isIAlu, legal, taken, waitExpired;
    logic [3:0] rAluOp;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Opcode/funct decode shared by the next-state and strobe logic
    always_comb begin
        isR     = (op == 6'h00);
        isLw    = (op == 6'h23);
        isSw    = (op == 6'h2B);
        isBeq   = (op == 6'h04);
        isBne   = (op == 6'h05);
        isAddi  = (op == 6'h08);
        isAddiu = (op == 6'h09);
        isAndi  = (op == 6'h0C);
        isOri   = (op == 6'h0D);
        isLui   = (op == 6'h0F);
        isJ     = (op == 6'h02);
        isIAlu  = isAddi | isAddiu | isAndi | isOri | isLui;
        rOk     = 1'b1;
        rAluOp  = 4'd0;
        case (funct)
            6'h20:   rAluOp = 4'd0;
            6'h22:   rAluOp = 4'd1;
            6'h24:   rAluOp = 4'd2;
            6'h25:   rAluOp = 4'd3;
            6'h2A:   rAluOp = 4'd4;
            default: rOk = 1'b0;
        endcase
        legal = (isR & rOk) | isLw | isSw | isBeq | isBne | isIAlu | isJ;
        taken = (isBeq & alu_zero) | (isBne & ~alu_zero);
        waitExpired = ~mem_ready && (waitCnt == LAST);
    end

    // State register and memory wait counter; a ready on the last allowed cycle still completes
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= FETCH;
            waitCnt <= '0;
        end else begin
            case (cur)
                FETCH: begin
                    if (mem_ready) begin
                        cur     <= DECODE;
                        waitCnt <= '0;
                    end else if (waitExpired) begin
                        cur <= FAULT;
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                DECODE: cur <= legal ? EXEC : FAULT;
                EXEC: begin
                    waitCnt <= '0;
                    if (isR | isIAlu)     cur <= WB;
                    else if (isLw | isSw) cur <= MEM;
                    else                  cur <= FETCH;
                end
                MEM: begin
                    if (mem_ready) begin
                        cur     <= isLw ? WB : FETCH;
                        waitCnt <= '0;
                    end else if (waitExpired) begin
                        cur <= FAULT;
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                WB: begin
                    cur     <= FETCH;
                    waitCnt <= '0;
                end
                FAULT:   cur <= FAULT;
                default: cur <= FAULT;
            endcase
        end
    end

    // Strobes decoded from the current state; everything is forced low while reset is held
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        sext       = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 4'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        fault      = 1'b0;
        state      = 3'd0;
        if (!rst) begin
            state = cur;
            if (cur == DECODE || cur == EXEC || cur == MEM || cur == WB)
                sext = isLw | isSw | isBeq | isBne | isAddi | isAddiu;
            case (cur)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                EXEC: begin
                    if (isR) begin
                        alu_op = rAluOp;
                    end else if (isIAlu) begin
                        alu_src_b = isLui ? 2'b11 : 2'b10;
                        alu_op    = isAndi ? 4'd2 : (isOri ? 4'd3 : 4'd0);
                    end else if (isLw | isSw) begin
                        alu_src_b = 2'b10;
                    end else if (isBeq | isBne) begin
                        alu_op     = 4'd1;
                        instr_done = 1'b1;
                        if (taken) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                    end else if (isJ) begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        instr_done = 1'b1;
                    end
                end
                MEM: begin
                    mem_read   = isLw;
                    mem_write  = isSw;
                    instr_done = isSw & mem_ready;
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = isR;
                    mem_to_reg = isLw;
                    instr_done = 1'b1;
                end
                FAULT:   fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
